// File: rtl/noc_radix_switch.sv
`default_nettype none
// ============================================================================
//  Module   : noc_radix_switch
//  Brief    : Radix-N NoC switch. One memory-to-core ingress FIFO routed by
//             destination field to per-core lanes, and N core-to-memory
//             ingress FIFOs merged onto the memory port by a round-robin
//             arbiter. All launches are registered; overflow is sticky.
//  Revision : 1.0  initial release
// ============================================================================
module noc_radix_switch #(
    parameter int RADIX      = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         FIFO_M2C_ENQ,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]             FIFO_M2C_IN,
    output logic                                         FIFO_M2C_FULL,
    output logic [RADIX-1:0]                             FIFO_M2C_ENQ_downstream,
    output logic [RADIX*(ADDR_WIDTH+DATA_WIDTH)-1:0]     FIFO_M2C_OUT,
    input  logic [RADIX-1:0]                             FIFO_M2C_FULL_downstream,
    input  logic [RADIX-1:0]                             FIFO_C2M_ENQ,
    input  logic [RADIX*(ADDR_WIDTH+DATA_WIDTH)-1:0]     FIFO_C2M_IN,
    output logic [RADIX-1:0]                             FIFO_C2M_FULL,
    output logic                                         FIFO_C2M_ENQ_downstream,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0]             FIFO_C2M_OUT,
    output logic [$clog2(RADIX)-1:0]                     FIFO_C2M_SRC,
    input  logic                                         FIFO_C2M_FULL_downstream,
    output logic [RADIX:0]                               OVF
);

    localparam int c_W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int c_S  = $clog2(RADIX);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // M2C ingress FIFO and destination router
    // ------------------------------------------------------------------
    logic [c_W-1:0]       r_m2c_mem [FIFO_DEPTH];
    logic [c_PW-1:0]      r_m2c_wp;
    logic [c_PW-1:0]      r_m2c_rp;
    logic [c_CW-1:0]      r_m2c_cnt;
    logic                 r_m2c_full;
    logic                 r_m2c_ovf;
    logic [RADIX-1:0]     r_m2c_enq_ds;
    logic [RADIX*c_W-1:0] r_m2c_out;

    logic                 w_m2c_wr;
    logic                 w_m2c_rd;
    logic [c_W-1:0]       w_m2c_head;
    logic [c_S-1:0]       w_m2c_dst;
    logic [c_CW-1:0]      w_m2c_cnt_nxt;
    logic [RADIX-1:0]     w_m2c_lane;

    // A write is refused while full; a same-cycle pop does not make room.
    assign w_m2c_wr      = FIFO_M2C_ENQ & ~r_m2c_full;
    assign w_m2c_head    = r_m2c_mem[r_m2c_rp];
    assign w_m2c_dst     = w_m2c_head[c_W-1 -: c_S];
    // Head-of-line: only the head is considered, so a blocked lane stalls all.
    assign w_m2c_rd      = (r_m2c_cnt != '0) & ~FIFO_M2C_FULL_downstream[w_m2c_dst];
    assign w_m2c_cnt_nxt = r_m2c_cnt + c_CW'(w_m2c_wr) - c_CW'(w_m2c_rd);

    // Decode the popped head into a one-hot lane launch
    always_comb begin
        w_m2c_lane = '0;
        for (int i = 0; i < RADIX; i++) begin
            w_m2c_lane[i] = w_m2c_rd & (w_m2c_dst == c_S'(i));
        end
    end

    // M2C storage array (contents are don't-care once the count is cleared)
    always_ff @(posedge clk) begin
        if (w_m2c_wr) begin
            r_m2c_mem[r_m2c_wp] <= FIFO_M2C_IN;
        end
    end

    // M2C pointers, count, full flag, sticky overflow and lane launch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m2c_wp     <= '0;
            r_m2c_rp     <= '0;
            r_m2c_cnt    <= '0;
            r_m2c_full   <= 1'b0;
            r_m2c_ovf    <= 1'b0;
            r_m2c_enq_ds <= '0;
            r_m2c_out    <= '0;
        end else begin
            if (w_m2c_wr) begin
                r_m2c_wp <= r_m2c_wp + c_PW'(1);
            end
            if (w_m2c_rd) begin
                r_m2c_rp <= r_m2c_rp + c_PW'(1);
            end
            r_m2c_cnt  <= w_m2c_cnt_nxt;
            r_m2c_full <= (w_m2c_cnt_nxt == c_DEPTH);
            if (FIFO_M2C_ENQ && r_m2c_full) begin
                r_m2c_ovf <= 1'b1;
            end
            r_m2c_enq_ds <= w_m2c_lane;
            for (int i = 0; i < RADIX; i++) begin
                if (w_m2c_lane[i]) begin
                    r_m2c_out[i*c_W +: c_W] <= w_m2c_head;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // C2M ingress FIFOs, one per core port
    // ------------------------------------------------------------------
    logic [RADIX-1:0]     w_c2m_nonempty;
    logic [RADIX-1:0]     w_c2m_gnt;
    logic [RADIX-1:0]     w_c2m_ovf;
    logic [RADIX*c_W-1:0] w_c2m_head;

    for (genvar gi = 0; gi < RADIX; gi++) begin : g_c2m
        logic [c_W-1:0]  r_mem [FIFO_DEPTH];
        logic [c_PW-1:0] r_wp;
        logic [c_PW-1:0] r_rp;
        logic [c_CW-1:0] r_cnt;
        logic            r_full;
        logic            r_ovf;
        logic            w_wr;
        logic            w_rd;
        logic [c_CW-1:0] w_cnt_nxt;

        assign w_wr      = FIFO_C2M_ENQ[gi] & ~r_full;
        assign w_rd      = w_c2m_gnt[gi];
        assign w_cnt_nxt = r_cnt + c_CW'(w_wr) - c_CW'(w_rd);

        assign w_c2m_nonempty[gi]        = (r_cnt != '0);
        assign w_c2m_head[gi*c_W +: c_W] = r_mem[r_rp];
        assign w_c2m_ovf[gi]             = r_ovf;
        assign FIFO_C2M_FULL[gi]         = r_full;

        // Per-port storage array
        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_mem[r_wp] <= FIFO_C2M_IN[gi*c_W +: c_W];
            end
        end

        // Per-port pointers, count, full flag and sticky overflow
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wp   <= '0;
                r_rp   <= '0;
                r_cnt  <= '0;
                r_full <= 1'b0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wp <= r_wp + c_PW'(1);
                end
                if (w_rd) begin
                    r_rp <= r_rp + c_PW'(1);
                end
                r_cnt  <= w_cnt_nxt;
                r_full <= (w_cnt_nxt == c_DEPTH);
                if (FIFO_C2M_ENQ[gi] && r_full) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // C2M round-robin arbiter and memory-side launch
    // ------------------------------------------------------------------
    logic [c_S-1:0] r_ptr;
    logic           r_c2m_enq_ds;
    logic [c_W-1:0] r_c2m_out;
    logic [c_S-1:0] r_c2m_src;

    logic           w_gnt_any;
    logic           w_gnt_fire;
    logic [c_S-1:0] w_gnt_idx;
    logic [c_W-1:0] w_gnt_flit;

    // First non-empty port at or after the priority pointer, wrapping around
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < RADIX; k++) begin
            if (!w_gnt_any && w_c2m_nonempty[r_ptr + c_S'(k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = r_ptr + c_S'(k);
            end
        end
    end

    assign w_gnt_fire = w_gnt_any & ~FIFO_C2M_FULL_downstream;

    // One-hot pop strobe and head-flit select for the granted port
    always_comb begin
        w_c2m_gnt  = '0;
        w_gnt_flit = '0;
        for (int k = 0; k < RADIX; k++) begin
            if (w_gnt_idx == c_S'(k)) begin
                w_c2m_gnt[k] = w_gnt_fire;
                w_gnt_flit   = w_c2m_head[k*c_W +: c_W];
            end
        end
    end

    // Priority pointer advance and registered memory-side launch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_c2m_enq_ds <= 1'b0;
            r_c2m_out    <= '0;
            r_c2m_src    <= '0;
        end else begin
            r_c2m_enq_ds <= w_gnt_fire;
            if (w_gnt_fire) begin
                r_ptr     <= w_gnt_idx + c_S'(1);
                r_c2m_out <= w_gnt_flit;
                r_c2m_src <= w_gnt_idx;
            end
        end
    end

    assign FIFO_M2C_FULL           = r_m2c_full;
    assign FIFO_M2C_ENQ_downstream = r_m2c_enq_ds;
    assign FIFO_M2C_OUT            = r_m2c_out;
    assign FIFO_C2M_ENQ_downstream = r_c2m_enq_ds;
    assign FIFO_C2M_OUT            = r_c2m_out;
    assign FIFO_C2M_SRC            = r_c2m_src;
    assign OVF                     = {w_c2m_ovf, r_m2c_ovf};

endmodule
`default_nettype wire

// File: tb/tb_noc_radix_switch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_radix_switch
//  Brief    : Scoreboard bench for noc_radix_switch (RADIX=2, W=40).
//             Stimulus pushes expected launches; a negedge monitor pops them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_noc_radix_switch;

    localparam int RADIX = 2;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int W     = AW + DW;

    logic             clk = 1'b0;
    logic             rst;
    logic             m2c_enq;
    logic [W-1:0]     m2c_in;
    logic             m2c_full;
    logic [RADIX-1:0] m2c_enq_ds;
    logic [2*W-1:0]   m2c_out;
    logic [RADIX-1:0] m2c_ds_full;
    logic [RADIX-1:0] c2m_enq;
    logic [2*W-1:0]   c2m_in;
    logic [RADIX-1:0] c2m_full;
    logic             c2m_enq_ds;
    logic [W-1:0]     c2m_out;
    logic [0:0]       c2m_src;
    logic             c2m_ds_full;
    logic [RADIX:0]   ovf;

    noc_radix_switch #(
        .RADIX      (RADIX),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .FIFO_M2C_ENQ             (m2c_enq),
        .FIFO_M2C_IN              (m2c_in),
        .FIFO_M2C_FULL            (m2c_full),
        .FIFO_M2C_ENQ_downstream  (m2c_enq_ds),
        .FIFO_M2C_OUT             (m2c_out),
        .FIFO_M2C_FULL_downstream (m2c_ds_full),
        .FIFO_C2M_ENQ             (c2m_enq),
        .FIFO_C2M_IN              (c2m_in),
        .FIFO_C2M_FULL            (c2m_full),
        .FIFO_C2M_ENQ_downstream  (c2m_enq_ds),
        .FIFO_C2M_OUT             (c2m_out),
        .FIFO_C2M_SRC             (c2m_src),
        .FIFO_C2M_FULL_downstream (c2m_ds_full),
        .OVF                      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           port;
        logic [W-1:0] flit;
        int           edge_n;   // expected posedge count at launch, -1 = any
    } exp_t;

    exp_t m2c_q[$];
    exp_t c2m_q[$];
    exp_t me;
    exp_t ce;

    int n_tests  = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int m2c_seen = 0;
    int c2m_seen = 0;

    logic [W-1:0] fa;
    logic [W-1:0] fb;
    logic [W-1:0] f [5];
    int           f_lane [5];
    logic [W-1:0] p0 [3];
    logic [W-1:0] p1 [3];
    logic [W-1:0] q0a;
    logic [W-1:0] q1a;
    logic [W-1:0] q1b;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m2c_enq_ds"}, 64'(m2c_enq_ds), 64'h0);
        check({tag, "_m2c_out"},    64'(|m2c_out),   64'h0);
        check({tag, "_m2c_full"},   64'(m2c_full),   64'h0);
        check({tag, "_c2m_enq_ds"}, 64'(c2m_enq_ds), 64'h0);
        check({tag, "_c2m_out"},    64'(c2m_out),    64'h0);
        check({tag, "_c2m_src"},    64'(c2m_src),    64'h0);
        check({tag, "_c2m_full"},   64'(c2m_full),   64'h0);
        check({tag, "_ovf"},        64'(ovf),        64'h0);
    endtask

    // Monitor: pop and compare whenever the DUT launches a flit
    always @(negedge clk) begin
        if (!rst) begin
            if (|m2c_enq_ds) begin
                m2c_seen++;
                check("m2c_onehot", 64'($countones(m2c_enq_ds)), 64'd1);
                for (int l = 0; l < RADIX; l++) begin
                    if (m2c_enq_ds[l]) begin
                        if (m2c_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL m2c_unexpected: lane %0d flit %0h, expected no launch", l, m2c_out[l*W +: W]);
                        end else begin
                            me = m2c_q.pop_front();
                            check("m2c_lane", 64'(l), 64'(me.port));
                            check("m2c_flit", 64'(m2c_out[l*W +: W]), 64'(me.flit));
                            if (me.edge_n >= 0) check("m2c_latency", 64'(edge_cnt), 64'(me.edge_n));
                        end
                    end
                end
            end
            if (c2m_enq_ds) begin
                c2m_seen++;
                if (c2m_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL c2m_unexpected: src %0d flit %0h, expected no launch", c2m_src, c2m_out);
                end else begin
                    ce = c2m_q.pop_front();
                    check("c2m_src",  64'(c2m_src), 64'(ce.port));
                    check("c2m_flit", 64'(c2m_out), 64'(ce.flit));
                    if (ce.edge_n >= 0) check("c2m_latency", 64'(edge_cnt), 64'(ce.edge_n));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int d;
        fa = {8'h05, 32'hDEAD_BEEF};
        fb = {8'h83, 32'h1234_5678};
        f[0] = {8'h01, 32'h1111_0000}; f_lane[0] = 0;
        f[1] = {8'h82, 32'h2222_0001}; f_lane[1] = 1;
        f[2] = {8'h83, 32'h3333_0002}; f_lane[2] = 1;
        f[3] = {8'h04, 32'h4444_0003}; f_lane[3] = 0;
        f[4] = {8'h85, 32'h5555_0004}; f_lane[4] = 1;
        p0[0] = {8'h20, 32'hA000_0000}; p1[0] = {8'hB0, 32'hB000_0000};
        p0[1] = {8'h21, 32'hA000_0001}; p1[1] = {8'hB1, 32'hB000_0001};
        p0[2] = {8'h22, 32'hA000_0002}; p1[2] = {8'hB2, 32'hB000_0002};
        q0a = {8'h40, 32'hC0C0_0000};
        q1a = {8'h51, 32'hD0D0_0001};
        q1b = {8'h52, 32'hD0D0_0002};

        rst         = 1'b1;
        m2c_enq     = 1'b0;
        m2c_in      = '0;
        m2c_ds_full = '0;
        c2m_enq     = '0;
        c2m_in      = '0;
        c2m_ds_full = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // Routing by destination MSB, 2-cycle latency, back-to-back
        m2c_enq = 1'b1;
        m2c_in  = fa;
        m2c_q.push_back('{0, fa, edge_cnt + 2});
        step();
        m2c_in  = fb;
        m2c_q.push_back('{1, fb, edge_cnt + 2});
        step();
        m2c_enq = 1'b0;
        step(4);
        check("m2c_count_routing", 64'(m2c_seen), 64'd2);
        check("m2c_hold_out",      64'(m2c_out[W-1:0]), 64'(fa));
        check("m2c_hold_out1",     64'(m2c_out[2*W-1:W]), 64'(fb));
        check("m2c_idle_strobe",   64'(m2c_enq_ds), 64'h0);

        // Fill with downstream blocked, overflow, then drain in order
        m2c_ds_full = 2'b11;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) check("m2c_full_before_last", 64'(m2c_full), 64'h0);
            if (i == 4) check("m2c_full_at_depth",    64'(m2c_full), 64'h1);
            m2c_enq = 1'b1;
            m2c_in  = f[i];
            if (i < 4) m2c_q.push_back('{f_lane[i], f[i], -1});
            step();
        end
        m2c_enq = 1'b0;
        step();
        check("m2c_ovf_set",  64'(ovf), 64'b001);
        check("m2c_full_hold", 64'(m2c_full), 64'h1);
        step(3);
        check("m2c_blocked_no_strobe", 64'(m2c_seen), 64'd2);
        m2c_ds_full = 2'b00;
        step(8);
        check("m2c_drain_count", 64'(m2c_seen), 64'd6);
        check("m2c_full_clear",  64'(m2c_full), 64'h0);
        check("m2c_ovf_sticky",  64'(ovf), 64'b001);

        // Round-robin alternation, one flit per cycle
        d = edge_cnt;
        for (int k = 0; k < 3; k++) begin
            c2m_q.push_back('{0, p0[k], d + 2 + 2*k});
            c2m_q.push_back('{1, p1[k], d + 3 + 2*k});
        end
        for (int c = 0; c < 3; c++) begin
            c2m_enq = 2'b11;
            c2m_in  = {p1[c], p0[c]};
            step();
        end
        c2m_enq = 2'b00;
        step(8);
        check("c2m_rr_count", 64'(c2m_seen), 64'd6);
        check("c2m_hold_src", 64'(c2m_src), 64'd1);
        check("c2m_hold_out", 64'(c2m_out), 64'(p1[2]));

        // Memory side blocked: no grant; release gives port 0 first
        c2m_ds_full = 1'b1;
        c2m_enq = 2'b10;
        c2m_in  = {q1a, {W{1'b0}}};
        step();
        c2m_enq = 2'b11;
        c2m_in  = {q1b, q0a};
        step();
        c2m_enq = 2'b00;
        step(4);
        check("c2m_blocked_no_grant", 64'(c2m_seen), 64'd6);
        c2m_q.push_back('{0, q0a, -1});
        c2m_q.push_back('{1, q1a, -1});
        c2m_q.push_back('{1, q1b, -1});
        c2m_ds_full = 1'b0;
        step(6);
        check("c2m_release_count", 64'(c2m_seen), 64'd9);

        // Buffer on both paths, overflow a C2M FIFO, then reset mid-operation
        m2c_ds_full = 2'b11;
        c2m_ds_full = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("c2m_full_port0", 64'(c2m_full), 64'b01);
            m2c_enq = (i < 2);
            m2c_in  = f[i];
            c2m_enq = {(i == 0), 1'b1};
            c2m_in  = {q1a, p0[i % 3]};
            step();
        end
        m2c_enq = 1'b0;
        c2m_enq = 2'b00;
        step();
        check("c2m_ovf_port0", 64'(ovf), 64'b011);
        check("m2c_partial_not_full", 64'(m2c_full), 64'h0);
        rst         = 1'b1;
        m2c_ds_full = 2'b00;
        c2m_ds_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midrst");
        step();
        rst = 1'b0;
        step(6);
        check("post_rst_no_m2c", 64'(m2c_seen), 64'd6);
        check("post_rst_no_c2m", 64'(c2m_seen), 64'd9);
        check("m2c_queue_empty", 64'(m2c_q.size()), 64'd0);
        check("c2m_queue_empty", 64'(c2m_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
